// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a fetch requester (i_*) and a load/store requester (d_*) onto a
//   single shared memory port (m_*). Only one transaction is ever outstanding.
//   Data requests normally win a tie. Fetch wins once it has been passed over
//   STARVE_LIMIT consecutive times.
//
//   Transaction flow: IDLE (grant + latch) -> REQ (valid/ready handshake)
//                     -> RESP (wait for response) -> ACK (one-cycle ack).
//
// Ports
//   clk_i, arstn_i         clock, asynchronous active-low reset
//   i_req_i, i_addr_i      fetch request (always a read)
//   i_rdata_o, i_ack_o,    fetch response; rdata holds until the next fetch ack
//   i_err_o
//   d_req_i, d_we_i,       load/store request
//   d_addr_i, d_wdata_i,
//   d_wstrb_i
//   d_rdata_o, d_ack_o,    load/store response; rdata holds until the next
//   d_err_o                data ack, and is zero for writes
//   m_req_valid_o/ready_i  shared memory request handshake
//   m_we_o, m_addr_o,      shared memory request payload
//   m_wdata_o, m_wstrb_o
//   m_resp_valid_i,        shared memory response
//   m_rdata_i, m_err_i
//   busy_o                 high whenever a transaction is in flight
//   grant_o                current owner: 00 none, 01 fetch, 10 data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  // fetch requester
  input  logic        i_req_i,
  input  logic [63:0] i_addr_i,
  output logic [63:0] i_rdata_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  // load/store requester
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  input  logic [7:0]  d_wstrb_i,
  output logic [63:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  // shared memory port
  output logic        m_req_valid_o,
  input  logic        m_req_ready_i,
  output logic        m_we_o,
  output logic [63:0] m_addr_o,
  output logic [63:0] m_wdata_o,
  output logic [7:0]  m_wstrb_o,
  input  logic        m_resp_valid_i,
  input  logic [63:0] m_rdata_i,
  input  logic        m_err_i,
  // status
  output logic        busy_o,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_FETCH = 2'b01;
  localparam logic [1:0] G_DATA  = 2'b10;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_owner;
  logic [1:0]  r_starve;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_i_rdata;
  logic [63:0] r_d_rdata;
  logic        r_err;

  logic        w_fetch_wins;
  logic        w_grant_data;
  logic        w_grant_fetch;

  // Fetch has waited long enough: it takes the next tie.
  assign w_fetch_wins = (32'(r_starve) == STARVE_LIMIT);

  // Next-state and grant decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (d_req_i && !(i_req_i && w_fetch_wins)) begin
          w_grant_data = 1'b1;
          w_state_nxt  = S_REQ;
        end else if (i_req_i) begin
          w_grant_fetch = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      S_REQ:   if (m_req_ready_i)  w_state_nxt = S_RESP;
      S_RESP:  if (m_resp_valid_i) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state   <= S_IDLE;
      r_owner   <= G_NONE;
      r_starve  <= 2'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          // Request payload is captured once; requester changes after the
          // grant have no effect on the memory request.
          if (w_grant_data) begin
            r_owner <= G_DATA;
            r_we    <= d_we_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
            r_wstrb <= d_wstrb_i;
          end else if (w_grant_fetch) begin
            r_owner <= G_FETCH;
            r_we    <= 1'b0;
            r_addr  <= i_addr_i;
            r_wdata <= '0;
            r_wstrb <= '0;
          end
          // Starve counter only counts data grants that overtook a waiting
          // fetch; it saturates at 3.
          if (!i_req_i || w_grant_fetch) begin
            r_starve <= 2'd0;
          end else if (w_grant_data && (r_starve != 2'd3)) begin
            r_starve <= r_starve + 2'd1;
          end
        end
        S_RESP: begin
          if (m_resp_valid_i) begin
            r_err <= m_err_i;
            if (r_owner == G_DATA) begin
              r_d_rdata <= r_we ? 64'd0 : m_rdata_i;
            end else begin
              r_i_rdata <= m_rdata_i;
            end
          end
        end
        S_ACK:   r_owner <= G_NONE;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign busy_o        = (r_state != S_IDLE);
  assign grant_o       = r_owner;

  assign m_req_valid_o = (r_state == S_REQ);
  assign m_we_o        = r_we;
  assign m_addr_o      = r_addr;
  assign m_wdata_o     = r_wdata;
  assign m_wstrb_o     = r_wstrb;

  assign i_ack_o       = (r_state == S_ACK) && (r_owner == G_FETCH);
  assign i_err_o       = i_ack_o && r_err;
  assign i_rdata_o     = r_i_rdata;

  assign d_ack_o       = (r_state == S_ACK) && (r_owner == G_DATA);
  assign d_err_o       = d_ack_o && r_err;
  assign d_rdata_o     = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. Inputs change 1 ns after the
//   rising edge and outputs are sampled there as well (all DUT outputs are
//   decoded from registers). The memory side is driven cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        i_req_i;
  logic [63:0] i_addr_i;
  logic [63:0] i_rdata_o;
  logic        i_ack_o;
  logic        i_err_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic [7:0]  d_wstrb_i;
  logic [63:0] d_rdata_o;
  logic        d_ack_o;
  logic        d_err_o;
  logic        m_req_valid_o;
  logic        m_req_ready_i;
  logic        m_we_o;
  logic [63:0] m_addr_o;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_wstrb_o;
  logic        m_resp_valid_i;
  logic [63:0] m_rdata_i;
  logic        m_err_i;
  logic        busy_o;
  logic [1:0]  grant_o;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .i_req_i       (i_req_i),
    .i_addr_i      (i_addr_i),
    .i_rdata_o     (i_rdata_o),
    .i_ack_o       (i_ack_o),
    .i_err_o       (i_err_o),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_wstrb_i     (d_wstrb_i),
    .d_rdata_o     (d_rdata_o),
    .d_ack_o       (d_ack_o),
    .d_err_o       (d_err_o),
    .m_req_valid_o (m_req_valid_o),
    .m_req_ready_i (m_req_ready_i),
    .m_we_o        (m_we_o),
    .m_addr_o      (m_addr_o),
    .m_wdata_o     (m_wdata_o),
    .m_wstrb_o     (m_wstrb_o),
    .m_resp_valid_i(m_resp_valid_i),
    .m_rdata_i     (m_rdata_i),
    .m_err_i       (m_err_i),
    .busy_o        (busy_o),
    .grant_o       (grant_o)
  );

  always #5 clk_i = ~clk_i;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Control outputs packed for compact comparisons:
  // {busy, grant[1:0], m_req_valid, m_we, i_ack, i_err, d_ack, d_err}
  function automatic logic [8:0] ctl();
    return {busy_o, grant_o, m_req_valid_o, m_we_o, i_ack_o, i_err_o, d_ack_o, d_err_o};
  endfunction

  task automatic idle_inputs();
    i_req_i        = 1'b0;
    i_addr_i       = '0;
    d_req_i        = 1'b0;
    d_we_i         = 1'b0;
    d_addr_i       = '0;
    d_wdata_i      = '0;
    d_wstrb_i      = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b0;
    m_rdata_i      = '0;
    m_err_i        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arstn_i = 1'b0;
    tick();
    tick();
    n_total++;
    if (ctl() !== 9'b0) begin
      $display("FAIL reset_ctl: got %b, required %b", ctl(), 9'b0);
    end else n_pass++;
    n_total++;
    if ({i_rdata_o, d_rdata_o, m_addr_o, m_wdata_o, m_wstrb_o} !== '0) begin
      $display("FAIL reset_data: got %h %h %h %h %h, required all zero",
               i_rdata_o, d_rdata_o, m_addr_o, m_wdata_o, m_wstrb_o);
    end else n_pass++;
    #4 arstn_i = 1'b1;
    tick();
    n_total++;
    if (ctl() !== 9'b0) begin
      $display("FAIL reset_release_idle: got %b, required %b", ctl(), 9'b0);
    end else n_pass++;
  endtask

  // Minimum-latency fetch read: grant c0, valid c1, resp c2, ack c3.
  task automatic test_fetch_read();
    i_req_i       = 1'b1;
    i_addr_i      = 64'h1000;
    m_req_ready_i = 1'b1;
    tick();  // cycle 1: REQ
    n_total++;
    if (ctl() !== 9'b1_01_1_0_0000 || m_addr_o !== 64'h1000) begin
      $display("FAIL fetch_req: ctl %b addr %h, required %b addr %h",
               ctl(), m_addr_o, 9'b1_01_1_0_0000, 64'h1000);
    end else n_pass++;
    tick();  // cycle 2: RESP
    n_total++;
    if (ctl() !== 9'b1_01_0_0_0000) begin
      $display("FAIL fetch_resp_wait: got %b, required %b", ctl(), 9'b1_01_0_0_0000);
    end else n_pass++;
    m_resp_valid_i = 1'b1;
    m_rdata_i      = 64'hDEAD_BEEF;
    tick();  // cycle 3: ACK
    n_total++;
    if (ctl() !== 9'b1_01_0_0_1000 || i_rdata_o !== 64'hDEAD_BEEF) begin
      $display("FAIL fetch_ack: ctl %b rdata %h, required %b rdata %h",
               ctl(), i_rdata_o, 9'b1_01_0_0_1000, 64'hDEAD_BEEF);
    end else n_pass++;
    m_resp_valid_i = 1'b0;
    m_rdata_i      = '0;
    i_req_i        = 1'b0;
    tick();  // back in IDLE; rdata must hold
    n_total++;
    if (ctl() !== 9'b0 || i_rdata_o !== 64'hDEAD_BEEF) begin
      $display("FAIL fetch_hold: ctl %b rdata %h, required %b rdata %h",
               ctl(), i_rdata_o, 9'b0, 64'hDEAD_BEEF);
    end else n_pass++;
  endtask

  // Tie: data write first, then the waiting fetch.
  task automatic test_priority();
    i_req_i   = 1'b1;
    i_addr_i  = 64'h3000;
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 64'h2000;
    d_wdata_i = 64'h55;
    d_wstrb_i = 8'h01;
    tick();  // REQ, data owner
    n_total++;
    if (ctl() !== 9'b1_10_1_1_0000 || m_addr_o !== 64'h2000 ||
        m_wdata_o !== 64'h55 || m_wstrb_o !== 8'h01) begin
      $display("FAIL prio_data_req: ctl %b addr %h wdata %h wstrb %h, required %b 2000 55 01",
               ctl(), m_addr_o, m_wdata_o, m_wstrb_o, 9'b1_10_1_1_0000);
    end else n_pass++;
    tick();  // RESP
    m_resp_valid_i = 1'b1;
    m_rdata_i      = 64'h1234_5678;  // must be zeroed for a write
    tick();  // ACK
    n_total++;
    if (ctl() !== 9'b1_10_0_1_0010 || d_rdata_o !== 64'd0) begin
      $display("FAIL prio_data_ack: ctl %b rdata %h, required %b rdata 0",
               ctl(), d_rdata_o, 9'b1_10_0_1_0010);
    end else n_pass++;
    m_resp_valid_i = 1'b0;
    d_req_i        = 1'b0;
    tick();  // IDLE, fetch granted
    tick();  // REQ, fetch owner
    n_total++;
    if (ctl() !== 9'b1_01_1_0_0000 || m_addr_o !== 64'h3000 ||
        m_wdata_o !== 64'd0 || m_wstrb_o !== 8'd0) begin
      $display("FAIL prio_fetch_req: ctl %b addr %h wdata %h wstrb %h, required %b 3000 0 0",
               ctl(), m_addr_o, m_wdata_o, m_wstrb_o, 9'b1_01_1_0_0000);
    end else n_pass++;
    tick();  // RESP
    m_resp_valid_i = 1'b1;
    m_rdata_i      = 64'hCAFE;
    tick();  // ACK
    n_total++;
    if (ctl() !== 9'b1_01_0_0_1000 || i_rdata_o !== 64'hCAFE || d_rdata_o !== 64'd0) begin
      $display("FAIL prio_fetch_ack: ctl %b i_rdata %h d_rdata %h, required %b CAFE 0",
               ctl(), i_rdata_o, d_rdata_o, 9'b1_01_0_0_1000);
    end else n_pass++;
    m_resp_valid_i = 1'b0;
    i_req_i        = 1'b0;
    tick();
  endtask

  // Both requests held: grants D D D F, then the counter restarts so D again.
  task automatic test_starvation();
    logic [1:0] exp_grant [5];
    exp_grant[0] = 2'b10;
    exp_grant[1] = 2'b10;
    exp_grant[2] = 2'b10;
    exp_grant[3] = 2'b01;
    exp_grant[4] = 2'b10;
    i_req_i       = 1'b1;
    i_addr_i      = 64'h4000;
    d_req_i       = 1'b1;
    d_we_i        = 1'b0;
    d_addr_i      = 64'h5000;
    m_req_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();  // REQ
      n_total++;
      if (grant_o !== exp_grant[k]) begin
        $display("FAIL starve_grant%0d: got %b, required %b", k, grant_o, exp_grant[k]);
      end else n_pass++;
      tick();  // RESP
      m_resp_valid_i = 1'b1;
      m_rdata_i      = 64'(k);
      tick();  // ACK
      m_resp_valid_i = 1'b0;
      if (k == 4) begin
        i_req_i = 1'b0;
        d_req_i = 1'b0;
      end
      tick();  // IDLE
    end
  endtask

  // Ready held low in REQ: request must stay stable, stale resp ignored.
  task automatic test_backpressure();
    m_req_ready_i = 1'b0;
    d_req_i       = 1'b1;
    d_we_i        = 1'b0;
    d_addr_i      = 64'h6000;
    tick();  // REQ
    d_addr_i       = 64'h9999;  // change after grant must be ignored
    m_resp_valid_i = 1'b1;      // ignored outside RESP
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (m_req_valid_o !== 1'b1 || m_addr_o !== 64'h6000 || d_ack_o !== 1'b0) begin
        $display("FAIL bp_stall%0d: valid %b addr %h ack %b, required 1 6000 0",
                 c, m_req_valid_o, m_addr_o, d_ack_o);
      end else n_pass++;
      tick();
    end
    m_resp_valid_i = 1'b0;
    m_req_ready_i  = 1'b1;
    tick();  // RESP
    tick();  // still RESP, no response yet
    n_total++;
    if (ctl() !== 9'b1_10_0_0_0000) begin
      $display("FAIL bp_resp_wait: got %b, required %b", ctl(), 9'b1_10_0_0_0000);
    end else n_pass++;
    m_resp_valid_i = 1'b1;
    m_rdata_i      = 64'h77;
    tick();  // ACK
    n_total++;
    if (d_ack_o !== 1'b1 || d_rdata_o !== 64'h77) begin
      $display("FAIL bp_ack: ack %b rdata %h, required 1 77", d_ack_o, d_rdata_o);
    end else n_pass++;
    m_resp_valid_i = 1'b0;
    d_req_i        = 1'b0;
    tick();
  endtask

  task automatic test_error();
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_addr_i  = 64'h7000;
    tick();  // REQ
    tick();  // RESP
    m_resp_valid_i = 1'b1;
    m_err_i        = 1'b1;
    m_rdata_i      = 64'hBAD;
    tick();  // ACK
    n_total++;
    if (ctl() !== 9'b1_10_0_0_0011) begin
      $display("FAIL err_ack: got %b, required %b", ctl(), 9'b1_10_0_0_0011);
    end else n_pass++;
    m_resp_valid_i = 1'b0;
    m_err_i        = 1'b0;
    d_req_i        = 1'b0;
    tick();
    n_total++;
    if (ctl() !== 9'b0) begin
      $display("FAIL err_clear: got %b, required %b", ctl(), 9'b0);
    end else n_pass++;
  endtask

  task automatic test_reset_in_resp();
    i_req_i  = 1'b1;
    i_addr_i = 64'h8000;
    tick();  // REQ
    tick();  // RESP
    n_total++;
    if (busy_o !== 1'b1 || grant_o !== 2'b01) begin
      $display("FAIL rr_in_resp: busy %b grant %b, required 1 01", busy_o, grant_o);
    end else n_pass++;
    #2 arstn_i = 1'b0;
    #1;
    n_total++;
    if (ctl() !== 9'b0 || {i_rdata_o, d_rdata_o, m_addr_o, m_wdata_o, m_wstrb_o} !== '0) begin
      $display("FAIL rr_async: ctl %b i_rdata %h d_rdata %h addr %h, required all zero",
               ctl(), i_rdata_o, d_rdata_o, m_addr_o);
    end else n_pass++;
    i_req_i        = 1'b0;
    m_resp_valid_i = 1'b1;  // stale response from the abandoned transaction
    m_rdata_i      = 64'h5A5A;
    tick();
    arstn_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if (ctl() !== 9'b0) begin
        $display("FAIL rr_stale%0d: got %b, required %b", c, ctl(), 9'b0);
      end else n_pass++;
    end
    m_resp_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_priority();
    test_starvation();
    test_backpressure();
    test_error();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
